// File: rtl/ctle_sched_pkg.sv
// ctle_sched_pkg: shared types and constants for the CTLE lane scheduler.
package ctle_sched_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [1:0] lane_idx_t;
    typedef logic [2:0] cnt_t;
    typedef logic [3:0] lat_cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(NUM_LANES);

endpackage

// File: rtl/ctle_sched_serializer.sv
// ctle_sched_serializer: captures the four model outputs and streams the
// first nlanes of them out with valid/ready handshaking.
module ctle_sched_serializer
    import ctle_sched_pkg::*;
#(
    parameter int OUT_W = 18
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_capture,
    input  cnt_t                              i_nlanes,
    input  logic [NUM_LANES-1:0][OUT_W-1:0]   i_model_out,
    input  logic                              i_out_ready,
    output logic                              o_out_valid,
    output logic [OUT_W-1:0]                  o_out_data,
    output logic                              o_out_last,
    output logic                              o_done
);

    logic [NUM_LANES-1:0][OUT_W-1:0] r_obuf;
    lane_idx_t                       r_idx;
    logic                            r_valid;
    logic                            r_last;
    logic [OUT_W-1:0]                r_data;
    lane_idx_t                       w_idx_inc;
    logic                            w_xfer;

    assign w_idx_inc = r_idx + 2'd1;
    assign w_xfer    = r_valid && i_out_ready;
    assign o_done    = w_xfer && r_last;

    // Capture the frame, then advance one lane per accepted transfer; data
    // only moves on a handshake so it holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_obuf  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_capture) begin
            r_obuf  <= i_model_out;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= i_model_out[0];
            r_last  <= (i_nlanes == 3'd1);
        end else if (w_xfer) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx  <= w_idx_inc;
                r_data <= r_obuf[w_idx_inc];
                r_last <= (({1'b0, w_idx_inc} + 3'd1) == i_nlanes);
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_last  = r_last;

endmodule

// File: rtl/ctle_lane_scheduler.sv
// ctle_lane_scheduler: packs a serial sample stream into 4-lane frames,
// fires the CTLE model for one cycle with the accumulated dt, and
// serializes the model outputs back into a stream.
// Optional macro CTLE_SCHED_DT_SAT_EN: saturating dt accumulator plus a
// sticky dt_sat flag; without it the accumulator wraps.
//
//   state | meaning
//   FILL  | accepting samples into the lane buffer
//   FIRE  | one cycle with model_dt = accumulated dt
//   WAIT  | counting down model latency
//   DRAIN | streaming captured model outputs
module ctle_lane_scheduler
    import ctle_sched_pkg::*;
#(
    parameter int IN_W      = 18,
    parameter int OUT_W     = 18,
    parameter int DT_W      = 18,
    parameter int MODEL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [DT_W-1:0]    in_dt,
    input  logic               flush,
    output logic [DT_W-1:0]    model_dt,
    output logic [IN_W-1:0]    model_in_0,
    output logic [IN_W-1:0]    model_in_1,
    output logic [IN_W-1:0]    model_in_2,
    output logic [IN_W-1:0]    model_in_3,
    input  logic [OUT_W-1:0]   model_out_0,
    input  logic [OUT_W-1:0]   model_out_1,
    input  logic [OUT_W-1:0]   model_out_2,
    input  logic [OUT_W-1:0]   model_out_3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy
`ifdef CTLE_SCHED_DT_SAT_EN
    ,
    output logic               dt_sat
`endif
);

    state_t                          r_state, w_state_nxt;
    cnt_t                            r_cnt, w_cnt_nxt, w_cnt_acc;
    cnt_t                            r_nlanes, w_nlanes_nxt;
    logic [DT_W-1:0]                 r_dt_acc, w_dt_nxt, w_dt_inc, w_dt_added, w_dt_post;
    logic [NUM_LANES-1:0][IN_W-1:0]  r_lane, w_lane_acc, w_lane_nxt, r_model_in;
    logic [IN_W-1:0]                 w_pad;
    lat_cnt_t                        r_lat, w_lat_nxt;
    logic [DT_W-1:0]                 r_model_dt;
    logic                            r_busy;
    logic                            w_accept, w_capture, w_done;
    logic [NUM_LANES-1:0][OUT_W-1:0] w_model_out;

    assign in_ready  = (r_state == FILL) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_dt_inc  = in_dt[DT_W-1] ? '0 : in_dt;
    assign w_cnt_acc = r_cnt + cnt_t'(w_accept);

`ifdef CTLE_SCHED_DT_SAT_EN
    localparam logic [DT_W:0] DT_MAX = (DT_W+1)'((1 << (DT_W-1)) - 1);
    logic [DT_W:0] w_dt_sum;
    logic          w_dt_over;
    logic          r_dt_sat;

    assign w_dt_sum   = {1'b0, r_dt_acc} + {1'b0, w_dt_inc};
    assign w_dt_over  = (w_dt_sum > DT_MAX);
    assign w_dt_added = w_dt_over ? DT_MAX[DT_W-1:0] : w_dt_sum[DT_W-1:0];

    // Sticky flag: any accepted sample that pushed dt past the signed max.
    always_ff @(posedge clk) begin
        if (rst) r_dt_sat <= 1'b0;
        else if (w_accept && w_dt_over) r_dt_sat <= 1'b1;
    end

    assign dt_sat = r_dt_sat;
`else
    assign w_dt_added = r_dt_acc + w_dt_inc;
`endif

    assign w_dt_post = w_accept ? w_dt_added : r_dt_acc;

    // Lane buffer with the incoming sample written at the current count.
    always_comb begin
        w_lane_acc = r_lane;
        if (w_accept) w_lane_acc[r_cnt[1:0]] = in_data;
    end

    // Next-state: accept first, then full-frame or flush decides FIRE.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_nlanes_nxt = r_nlanes;
        w_dt_nxt     = r_dt_acc;
        w_lane_nxt   = r_lane;
        w_lat_nxt    = r_lat;
        w_capture    = 1'b0;
        w_pad        = w_lane_acc[w_cnt_acc[1:0] - 2'd1];
        case (r_state)
            FILL: begin
                w_cnt_nxt  = w_cnt_acc;
                w_dt_nxt   = w_dt_post;
                w_lane_nxt = w_lane_acc;
                if (w_cnt_acc == FULL_CNT) begin
                    w_state_nxt  = FIRE;
                    w_nlanes_nxt = FULL_CNT;
                end else if (flush && (w_cnt_acc != '0)) begin
                    w_state_nxt  = FIRE;
                    w_nlanes_nxt = w_cnt_acc;
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (cnt_t'(k) >= w_cnt_acc) w_lane_nxt[k] = w_pad;
                    end
                end
            end
            FIRE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
                w_dt_nxt    = '0;
                w_lat_nxt   = lat_cnt_t'(MODEL_LAT);
            end
            WAIT: begin
                if (r_lat <= lat_cnt_t'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DRAIN;
                end else begin
                    w_lat_nxt = r_lat - lat_cnt_t'(1);
                end
            end
            DRAIN: begin
                if (w_done) w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // State and datapath registers; model_dt/model_in load on entry to FIRE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_nlanes   <= '0;
            r_dt_acc   <= '0;
            r_lane     <= '0;
            r_lat      <= '0;
            r_model_dt <= '0;
            r_model_in <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_nlanes   <= w_nlanes_nxt;
            r_dt_acc   <= w_dt_nxt;
            r_lane     <= w_lane_nxt;
            r_lat      <= w_lat_nxt;
            r_model_dt <= (w_state_nxt == FIRE) ? w_dt_nxt : '0;
            if (w_state_nxt == FIRE) r_model_in <= w_lane_nxt;
            r_busy     <= (w_state_nxt != FILL) || (w_cnt_nxt != '0);
        end
    end

    assign w_model_out = {model_out_3, model_out_2, model_out_1, model_out_0};

    ctle_sched_serializer #(
        .OUT_W (OUT_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_capture   (w_capture),
        .i_nlanes    (r_nlanes),
        .i_model_out (w_model_out),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_done      (w_done)
    );

    assign model_dt   = r_model_dt;
    assign model_in_0 = r_model_in[0];
    assign model_in_1 = r_model_in[1];
    assign model_in_2 = r_model_in[2];
    assign model_in_3 = r_model_in[3];
    assign busy       = r_busy;

endmodule

// File: doc/ctle_lane_scheduler.md
Name: ctle_lane_scheduler

Overview:
- Sequences the 4-lane CTLE interpolation model (`in_0..in_3`, `out_0..out_3`, `dt`, `clk`, `rst`).
- Collects a serial stream of fixed-point samples, each with a per-sample time step, into 4-lane frames. Fires the model for exactly one cycle with the accumulated frame dt, then serializes the 4 model outputs back into a stream.
- Holds model state between frames by driving `dt` = 0. Sits between the channel sample source and the model instance in the fixed-point CTLE testbench/emulator top.

Parameters:
- IN_W, 18, width of input sample and model lane inputs (signed fixed-point, raw integer).
- OUT_W, 18, width of model lane outputs and output stream data (signed).
- DT_W, 18, width of `in_dt`, frame dt accumulator and `model_dt` (signed; only non-negative values are used).
- MODEL_LAT, 1, cycles from the FIRE cycle to valid `model_out_*`; legal range 1..15.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler accepts input.
- in_data  in  IN_W  input sample.
- in_dt  in  DT_W  time step attributed to this sample.
- flush  in  1  close a partial frame.
- model_dt  out  DT_W  dt to model; 0 except during FIRE.
- model_in_0..model_in_3  out  IN_W each  lane inputs to model.
- model_out_0..model_out_3  in  OUT_W each  lane outputs from model.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  output sample.
- out_last  out  1  final sample of a frame.
- busy  out  1  state != FILL, or cnt != 0.

Behaviour:
- All outputs are registered except `in_ready`, which decodes from state.
- Reset: state=FILL; cnt=0; dt_acc=0; nlanes=0; lane buffer=0; obuf=0; model_dt=0; model_in_*=0; out_valid=0; out_last=0; out_data=0; busy=0. `in_ready`=0 while rst is high.
- FILL: `in_ready`=1.
  - Accept: on `in_valid`&&`in_ready`, lane[cnt]<=`in_data`; dt_acc<=dt_acc+max(`in_dt`,0); cnt++.
  - When the 4th sample is accepted: nlanes<=4, go to FIRE.
  - Flush: `flush` with cnt>0 (after any same-cycle accept) pads lanes cnt..3 with the last stored sample, sets nlanes=cnt (post-accept), and goes to FIRE. Accept takes priority, then flush is applied.
  - `flush` with cnt==0 and no accept is ignored.
- FIRE (exactly 1 cycle):
  - `model_dt`=dt_acc; `model_in_k`=lane[k] (`model_in` is registered, so it is stable from FIRE onward); `in_ready`=0.
  - Next cycle: `model_dt`=0, dt_acc=0, cnt=0, latency counter=MODEL_LAT, go to WAIT.
- WAIT: decrement the latency counter. When it reaches 1, capture `model_out_0..3` into obuf on that edge (i.e. sample model outputs MODEL_LAT cycles after the FIRE cycle), set idx=0, go to DRAIN.
- DRAIN:
  - `out_valid`=1, `out_data`=obuf[idx], `out_last`=(idx==nlanes-1).
  - On `out_valid`&&`out_ready`: idx++. After the last lane, `out_valid`<=0 and go to FILL.
  - Padded lanes are never emitted.
  - `out_data` must not change while `out_valid`&&!`out_ready`.
- No overlap between frames. Minimum frame period is 4 accepts + 1 + MODEL_LAT + nlanes cycles.
- `model_in_*` hold their last values outside FIRE (model sees dt=0, so its state is frozen).
- dt arithmetic: `in_dt` negative is clamped to 0 before accumulation. Without the macro, dt_acc wraps modulo 2^DT_W (only the DT_W-bit result is kept).
- Reset mid-frame (any state) discards buffered samples and obuf; the partial output stream is truncated with no `out_last`.

Optional Feature:
- Macro: CTLE_SCHED_DT_SAT_EN.
- Defined: dt_acc saturates at 2^(DT_W-1)-1, and a sticky `dt_sat` flag output (1 bit, cleared by rst) sets on any saturation event.
- Undefined: wrap-around as above; the `dt_sat` port does not exist.

Decomposition:
- Package ctle_sched_pkg:
  - state enum {FILL, FIRE, WAIT, DRAIN};
  - NUM_LANES=4;
  - lane_idx_t (2 bits);
  - cnt_t (3 bits, 0..4);
  - lat_cnt_t (4 bits).
- One sub-module, ctle_sched_serializer: obuf capture, idx, and valid/ready/last output logic, driven by a capture strobe and nlanes.

Test Plan:
- Full frame: samples 100,200,300,400 with `in_dt`=5 each, MODEL_LAT=1, `out_ready`=1 → one FIRE cycle with `model_dt`=20, `model_in`=100/200/300/400; `model_dt`=0 on every other cycle; 4 outputs equal to `model_out` sampled 1 cycle after FIRE; `out_last` on the 4th.
- Flush: 2 samples 7,9 (`in_dt`=3), then `flush` → `model_in`=7,9,9,9; `model_dt`=6; exactly 2 outputs, `out_last` on the 2nd.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-drain → `out_data` and `out_valid` stable, `in_ready`=0 throughout, no sample lost or duplicated.
- dt edge: DT_W=8, four `in_dt`=40 → without macro `model_dt`=160 mod 256 = 160, read as signed = -96; with CTLE_SCHED_DT_SAT_EN `model_dt`=127 and `dt_sat`=1. A negative `in_dt` of -5 contributes 0.
- Reset mid-WAIT with MODEL_LAT=3: assert rst for 1 cycle → next cycle all outputs at reset values, `busy`=0, no outputs emitted for the aborted frame.
- Simultaneous accept+flush at cnt=1 → cnt becomes 2, nlanes=2, FIRE on the next cycle.
